// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  // Fetch FSM: request in flight (ISSUE/WAIT) or beat on offer (PRESENT).
  typedef enum logic [1:0] {
    ISSUE   = 2'd0,
    WAIT    = 2'd1,
    PRESENT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] START_PC_DEFAULT = 32'h8002_0000;
  localparam logic [31:0] PC_INC_DEFAULT   = 32'd4;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  // Force an address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Memory read port and decode beat port of the fetch stage.
interface fetch_if;

  // instruction memory side
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  // decode side
  logic        stall;
  logic [31:0] pc;
  logic [31:0] insn;
  logic        valid_insn;

  modport master (
    output mem_req, mem_addr, pc, insn, valid_insn,
    input  mem_ready, mem_rdata, stall
  );

  modport slave (
    input  mem_req, mem_addr, pc, insn, valid_insn,
    output mem_ready, mem_rdata, stall
  );

endinterface

// File: rtl/fetch.sv
// Instruction fetch stage: walks the PC, reads one word at a time from
// instruction memory and offers each word to decode for one beat. A redirect
// from execute retargets the next fetch; a request already accepted by memory
// is allowed to finish and its data is dropped (squash).
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] START_PC = START_PC_DEFAULT,
  parameter logic [31:0] PC_INC   = PC_INC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     bus,
  output logic [31:0] insn_count
);

  fetch_state_e state_r, state_s;
  logic [31:0]  fetch_pc_r, fetch_pc_s;
  logic         squash_r, squash_s;
  logic         mem_req_r, mem_req_s;
  logic [31:0]  mem_addr_r, mem_addr_s;
  logic [31:0]  pc_r, pc_s;
  logic [31:0]  insn_r, insn_s;
  logic         valid_r, valid_s;
  logic [31:0]  count_r, count_s;
  logic [31:0]  target_s;
  logic         resp_s;

  // A response only counts while a request is actually on the bus; this keeps
  // the idle cycle right after reset (mem_req low) from consuming mem_ready.
  assign resp_s = mem_req_r & bus.mem_ready & ((state_r == ISSUE) | (state_r == WAIT));

  assign target_s = align_word(redirect_pc);

  // Next-state and next-register values for the fetch FSM.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    squash_s   = squash_r;
    pc_s       = pc_r;
    insn_s     = insn_r;
    valid_s    = valid_r;
    count_s    = count_r;

    if (resp_s) begin
      // Memory completes the request this cycle.
      if (redirect_valid) begin
        fetch_pc_s = target_s;
        squash_s   = 1'b0;
        state_s    = ISSUE;
      end else if (squash_r) begin
        squash_s = 1'b0;
        state_s  = ISSUE;
      end else begin
        insn_s     = bus.mem_rdata;
        pc_s       = fetch_pc_r;
        fetch_pc_s = fetch_pc_r + PC_INC;
        valid_s    = 1'b1;
        state_s    = PRESENT;
      end
    end else begin
      case (state_r)
        ISSUE: begin
          // Not accepted yet, so the address may still be changed.
          if (redirect_valid) begin
            fetch_pc_s = target_s;
            state_s    = ISSUE;
          end else if (mem_req_r) begin
            state_s = WAIT;
          end else begin
            state_s = ISSUE;
          end
        end
        WAIT: begin
          // Accepted request must finish on its original address.
          if (redirect_valid) begin
            fetch_pc_s = target_s;
            squash_s   = 1'b1;
            state_s    = WAIT;
          end else begin
            state_s = WAIT;
          end
        end
        PRESENT: begin
          if (redirect_valid) begin
            valid_s    = 1'b0;
            fetch_pc_s = target_s;
            state_s    = ISSUE;
          end else if (!bus.stall) begin
            valid_s = 1'b0;
            count_s = count_r + 32'd1;
            state_s = ISSUE;
          end else begin
            state_s = PRESENT;
          end
        end
        default: begin
          state_s  = ISSUE;
          valid_s  = 1'b0;
          squash_s = 1'b0;
        end
      endcase
    end

    // Bus outputs are registered: they follow the state being entered.
    mem_req_s  = (state_s != PRESENT);
    mem_addr_s = ((state_s == WAIT) && squash_s) ? mem_addr_r : fetch_pc_s;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ISSUE;
      fetch_pc_r <= align_word(START_PC);
      squash_r   <= 1'b0;
      mem_req_r  <= 1'b0;
      mem_addr_r <= align_word(START_PC);
      pc_r       <= 32'd0;
      insn_r     <= 32'd0;
      valid_r    <= 1'b0;
      count_r    <= 32'd0;
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      squash_r   <= squash_s;
      mem_req_r  <= mem_req_s;
      mem_addr_r <= mem_addr_s;
      pc_r       <= pc_s;
      insn_r     <= insn_s;
      valid_r    <= valid_s;
      count_r    <= count_s;
    end
  end

  assign bus.mem_req    = mem_req_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.pc         = pc_r;
  assign bus.insn       = insn_r;
  assign bus.valid_insn = valid_r;
  assign insn_count     = count_r;

endmodule
